// File: rtl/ifu_pkg.sv
// ifu_pkg: shared core-wide types and constants for the instruction fetch unit.
// Provides XLEN/INST_W widths, the reset PC, the fetch FSM state enum and the
// queue entry payload struct.
package ifu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned QCNT_W = 2;

    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// ifu_queue: 2-entry FIFO of {inst, pc} between the fetch FSM and decode.
// Ports:
//   clock, reset           core clock, asynchronous active-high reset
//   push_i, push_inst_i,
//   push_pc_i              write a new entry at the tail
//   pop_i                  retire the head entry (ignored when empty)
//   flush_i                drop all entries; wins over push/pop
//   head_valid_o           queue non-empty
//   head_inst_o, head_pc_o head entry (registered, zero after reset)
//   count_o                occupancy 0..2
module ifu_queue
    import ifu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic [XLEN-1:0]   push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              head_valid_o,
    output logic [INST_W-1:0] head_inst_o,
    output logic [XLEN-1:0]   head_pc_o,
    output logic [QCNT_W-1:0] count_o
);

    ifu_entry_t        slot0_q, slot0_d;
    ifu_entry_t        slot1_q, slot1_d;
    logic [QCNT_W-1:0] count_q, count_d;
    ifu_entry_t        new_entry;
    logic              do_push;
    logic              do_pop;

    assign new_entry = '{inst: push_inst_i, pc: push_pc_i};

    // Slot0 is always the head; entries shift down on pop.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != QCNT_W'(0));
        do_push = push_i && ((count_q != QCNT_W'(2)) || do_pop);
        if (flush_i) begin
            count_d = QCNT_W'(0);
        end else begin
            case ({do_push, do_pop})
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - QCNT_W'(1);
                end
                2'b10: begin
                    if (count_q == QCNT_W'(0)) slot0_d = new_entry;
                    else                       slot1_d = new_entry;
                    count_d = count_q + QCNT_W'(1);
                end
                2'b11: begin
                    if (count_q == QCNT_W'(1)) begin
                        slot0_d = new_entry;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_valid_o = (count_q != QCNT_W'(0));
    assign head_inst_o  = slot0_q.inst;
    assign head_pc_o    = slot0_q.pc;
    assign count_o      = count_q;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Holds the fetch PC, issues one outstanding
// 32-bit read at a time to instruction memory, buffers responses in a 2-entry
// queue and hands them to decode with valid/ready. A redirect flushes the
// queue, retargets the PC and discards any in-flight response.
// Ports:
//   clock, reset                   core clock, asynchronous active-high reset
//   io_imem_req_valid/ready/addr   fetch request channel
//   io_imem_resp_valid/data        fetch response (one pulse per request)
//   io_redirect_valid/pc           redirect strobe and target
//   io_inst_valid/ready, io_inst,
//   io_pc                          head instruction toward decode
//   io_fetch_count                 decode handshake counter (IFU_PERF_EN only)
// Optional feature macro: IFU_PERF_EN
module ifu
    import ifu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic              io_imem_req_valid,
    input  logic              io_imem_req_ready,
    output logic [XLEN-1:0]   io_imem_req_addr,
    input  logic              io_imem_resp_valid,
    input  logic [INST_W-1:0] io_imem_resp_data,
    input  logic              io_redirect_valid,
    input  logic [XLEN-1:0]   io_redirect_pc,
    output logic              io_inst_valid,
    input  logic              io_inst_ready,
    output logic [INST_W-1:0] io_inst,
    output logic [XLEN-1:0]   io_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]       io_fetch_count
`endif
);

    ifu_state_t        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic              req_valid_q;
    logic              push;
    logic              pop;
    logic              flush;
    logic              req_fire;
    logic [QCNT_W-1:0] count;
    logic [QCNT_W-1:0] cnt_after;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^io_redirect_pc[1:0];

    assign pop      = io_inst_valid && io_inst_ready;
    assign req_fire = (state_q == REQ) && io_imem_req_ready;
    // Occupancy once a non-dropped response in WAIT lands alongside any pop.
    assign cnt_after = count + QCNT_W'(!drop_q) - QCNT_W'(pop);

    // Fetch FSM, PC, credit and drop control; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count < QCNT_W'(2)) state_d = REQ;
            end
            REQ: begin
                if (io_imem_req_ready) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    req_pc_d   = fetch_pc_q;
                end
            end
            WAIT: begin
                if (io_imem_resp_valid) begin
                    push    = !drop_q;
                    drop_d  = 1'b0;
                    state_d = (cnt_after < QCNT_W'(2)) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (io_redirect_valid) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = {io_redirect_pc[XLEN-1:2], 2'b00};
            // A request still owed by memory must be waited out and its data dropped.
            if (req_fire || ((state_q == WAIT) && !io_imem_resp_valid)) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            drop_q      <= drop_d;
            req_valid_q <= (state_d == REQ);
        end
    end

    assign io_imem_req_valid = req_valid_q;
    assign io_imem_req_addr  = fetch_pc_q;

    ifu_queue u_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_inst_i  (io_imem_resp_data),
        .push_pc_i    (req_pc_q),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_valid_o (io_inst_valid),
        .head_inst_o  (io_inst),
        .head_pc_o    (io_pc),
        .count_o      (count)
    );

`ifdef IFU_PERF_EN
    logic [63:0] fetch_count_q;

    // Counts decode handshakes; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) fetch_count_q <= '0;
        else if (pop) fetch_count_q <= fetch_count_q + 64'd1;
    end

    assign io_fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed self-checking bench for ifu. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [63:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_inst_valid;
    logic        io_inst_ready;
    logic [31:0] io_inst;
    logic [63:0] io_pc;
`ifdef IFU_PERF_EN
    logic [63:0] io_fetch_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ifu dut (
        .clock              (clock),
        .reset              (reset),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_pc     (io_redirect_pc),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_inst            (io_inst),
        .io_pc              (io_pc)
`ifdef IFU_PERF_EN
        ,
        .io_fetch_count     (io_fetch_count)
`endif
    );

    task automatic tick();
        @(negedge clock);
    endtask

    // Reset with all inputs idle; returns on the negedge where reset drops.
    task automatic do_reset();
        reset = 1'b1;
        io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'b0; io_imem_resp_data = '0;
        io_redirect_valid = 1'b0; io_redirect_pc = '0; io_inst_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({io_imem_req_valid, io_imem_req_addr, io_inst_valid, io_inst, io_pc} !==
            {1'b0, 64'h8000_0000, 1'b0, 32'h0, 64'h0}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h",
                {io_imem_req_valid, io_imem_req_addr, io_inst_valid, io_inst, io_pc},
                {1'b0, 64'h8000_0000, 1'b0, 32'h0, 64'h0});
        end
        do_reset();
        tick();
        checks++;
        if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
            failures++;
            $display("FAIL first_req got=%h exp=%h", {io_imem_req_valid, io_imem_req_addr}, {1'b1, 64'h8000_0000});
        end
    endtask

    task automatic test_fetch();
        do_reset();
        io_imem_req_ready = 1'b1; io_inst_ready = 1'b1;
        tick(); // REQ 0x80000000
        tick(); // WAIT
        checks++;
        if (io_imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_wait0 req_valid got=%b exp=0", io_imem_req_valid);
        end
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h0010_0093;
        tick();
        checks++;
        if ({io_inst_valid, io_inst, io_pc, io_imem_req_valid, io_imem_req_addr} !==
            {1'b1, 32'h0010_0093, 64'h8000_0000, 1'b1, 64'h8000_0004}) begin
            failures++;
            $display("FAIL fetch_inst0 got=%h exp=%h",
                {io_inst_valid, io_inst, io_pc, io_imem_req_valid, io_imem_req_addr},
                {1'b1, 32'h0010_0093, 64'h8000_0000, 1'b1, 64'h8000_0004});
        end
        io_imem_resp_valid = 1'b0;
        tick();
        checks++;
        if ({io_inst_valid, io_imem_req_valid} !== 2'b00) begin
            failures++; $display("FAIL fetch_gap got=%b exp=00", {io_inst_valid, io_imem_req_valid});
        end
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h0020_0113;
        tick();
        checks++;
        if ({io_inst_valid, io_inst, io_pc, io_imem_req_addr} !==
            {1'b1, 32'h0020_0113, 64'h8000_0004, 64'h8000_0008}) begin
            failures++;
            $display("FAIL fetch_inst1 got=%h exp=%h",
                {io_inst_valid, io_inst, io_pc, io_imem_req_addr},
                {1'b1, 32'h0020_0113, 64'h8000_0004, 64'h8000_0008});
        end
        io_imem_resp_valid = 1'b0; io_imem_req_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        io_imem_req_ready = 1'b1; io_inst_ready = 1'b0;
        tick(); tick();
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'hAAAA_0001;
        tick();
        io_imem_resp_valid = 1'b0;
        tick();
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'hBBBB_0002;
        tick();
        io_imem_resp_valid = 1'b0;
        // Queue full: no third request for several cycles.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({io_imem_req_valid, io_inst_valid, io_inst} !== {1'b0, 1'b1, 32'hAAAA_0001}) begin
                failures++;
                $display("FAIL full_hold[%0d] got=%h exp=%h", i,
                    {io_imem_req_valid, io_inst_valid, io_inst}, {1'b0, 1'b1, 32'hAAAA_0001});
            end
            if (i < 3) tick();
        end
        io_inst_ready = 1'b1;
        tick();
        io_inst_ready = 1'b0;
        checks++;
        if ({io_inst_valid, io_inst, io_pc} !== {1'b1, 32'hBBBB_0002, 64'h8000_0004}) begin
            failures++;
            $display("FAIL full_second got=%h exp=%h", {io_inst_valid, io_inst, io_pc},
                {1'b1, 32'hBBBB_0002, 64'h8000_0004});
        end
        tick();
        checks++;
        if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 64'h8000_0008}) begin
            failures++;
            $display("FAIL third_req got=%h exp=%h", {io_imem_req_valid, io_imem_req_addr}, {1'b1, 64'h8000_0008});
        end
        io_imem_req_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        io_imem_req_ready = 1'b1; io_inst_ready = 1'b0;
        tick(); tick();
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h1111_1111;
        tick();
        io_imem_resp_valid = 1'b0;
        tick(); // second request in WAIT, one entry buffered
        io_redirect_valid = 1'b1; io_redirect_pc = 64'h8000_1002;
        tick();
        io_redirect_valid = 1'b0;
        checks++;
        if ({io_inst_valid, io_imem_req_valid} !== 2'b00) begin
            failures++; $display("FAIL redir_flush got=%b exp=00", {io_inst_valid, io_imem_req_valid});
        end
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'hDEAD_BEEF;
        tick();
        io_imem_resp_valid = 1'b0;
        checks++;
        if ({io_inst_valid, io_imem_req_valid, io_imem_req_addr} !== {1'b0, 1'b1, 64'h8000_1000}) begin
            failures++;
            $display("FAIL redir_newreq got=%h exp=%h", {io_inst_valid, io_imem_req_valid, io_imem_req_addr},
                {1'b0, 1'b1, 64'h8000_1000});
        end
        tick();
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h0030_0193;
        tick();
        io_imem_resp_valid = 1'b0; io_imem_req_ready = 1'b0;
        checks++;
        if ({io_inst_valid, io_inst, io_pc} !== {1'b1, 32'h0030_0193, 64'h8000_1000}) begin
            failures++;
            $display("FAIL redir_target_inst got=%h exp=%h", {io_inst_valid, io_inst, io_pc},
                {1'b1, 32'h0030_0193, 64'h8000_1000});
        end
    endtask

    task automatic test_redirect_resp_pop();
        do_reset();
        io_imem_req_ready = 1'b1; io_inst_ready = 1'b0;
        tick(); tick();
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h2222_2222;
        tick();
        io_imem_resp_valid = 1'b0;
        tick();
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h3333_3333;
        io_redirect_valid = 1'b1; io_redirect_pc = 64'h9000_0008; io_inst_ready = 1'b1;
        tick();
        io_imem_resp_valid = 1'b0; io_redirect_valid = 1'b0; io_inst_ready = 1'b0;
        checks++;
        if ({io_inst_valid, io_imem_req_valid} !== 2'b00) begin
            failures++; $display("FAIL coinc_empty got=%b exp=00", {io_inst_valid, io_imem_req_valid});
        end
        tick();
        checks++;
        if ({io_inst_valid, io_imem_req_valid, io_imem_req_addr} !== {1'b0, 1'b1, 64'h9000_0008}) begin
            failures++;
            $display("FAIL coinc_req got=%h exp=%h", {io_inst_valid, io_imem_req_valid, io_imem_req_addr},
                {1'b0, 1'b1, 64'h9000_0008});
        end
    endtask

    task automatic test_stall();
        do_reset();
        io_imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {io_imem_req_valid, io_imem_req_addr},
                    {1'b1, 64'h8000_0000});
            end
            if (i < 4) tick();
        end
        io_imem_req_ready = 1'b1;
        tick();
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h4444_4444;
        tick();
        io_imem_resp_valid = 1'b0;
        checks++;
        if ({io_imem_req_valid, io_imem_req_addr, io_pc} !== {1'b1, 64'h8000_0004, 64'h8000_0000}) begin
            failures++;
            $display("FAIL stall_advance got=%h exp=%h", {io_imem_req_valid, io_imem_req_addr, io_pc},
                {1'b1, 64'h8000_0004, 64'h8000_0000});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        io_imem_req_ready = 1'b0;
        tick();
        io_redirect_valid = 1'b1; io_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        io_redirect_valid = 1'b0;
        checks++;
        if (io_imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL wrap_withdraw got=%b exp=0", io_imem_req_valid);
        end
        tick();
        checks++;
        if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_req got=%h exp=%h", {io_imem_req_valid, io_imem_req_addr},
                {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
        end
        io_imem_req_ready = 1'b1;
        tick();
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h5555_5555;
        tick();
        io_imem_resp_valid = 1'b0;
        checks++;
        if ({io_imem_req_valid, io_imem_req_addr, io_inst_valid, io_pc} !==
            {1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_next got=%h exp=%h", {io_imem_req_valid, io_imem_req_addr, io_inst_valid, io_pc},
                {1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
        end
    endtask

    initial begin
        reset = 1'b1;
        io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'b0; io_imem_resp_data = '0;
        io_redirect_valid = 1'b0; io_redirect_pc = '0; io_inst_ready = 1'b0;
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp_pop();
        test_stall();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
